// File: rtl/fp_pkg.sv
// Shared FP16 constants and the scheduler state type.
package fp_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_argext_scheduler_if.sv
// Candidate stream, control and result handshake for fp_argext_scheduler.
interface fp_argext_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 1024
);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic                  start;
    logic [IDX_W:0]        len;
    logic                  find_min;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_val;
    logic [IDX_W-1:0]      res_idx;

    modport master (
        output start, len, find_min, in_valid, in_data, res_ready,
        input  in_ready, busy, res_valid, res_val, res_idx
    );

    modport slave (
        input  start, len, find_min, in_valid, in_data, res_ready,
        output in_ready, busy, res_valid, res_val, res_idx
    );

endinterface

// File: rtl/fp_comparator.sv
// Combinational sign-magnitude greater-than for FP16 values: result = (num1 > num2).
// NaN is not handled; +0 is treated as greater than -0.
module fp_comparator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] num1,
    input  logic [DATA_WIDTH-1:0] num2,
    output logic                  result
);

    logic                  sign1;
    logic                  sign2;
    logic [DATA_WIDTH-2:0] mag1;
    logic [DATA_WIDTH-2:0] mag2;

    assign sign1 = num1[DATA_WIDTH-1];
    assign sign2 = num2[DATA_WIDTH-1];
    assign mag1  = num1[DATA_WIDTH-2:0];
    assign mag2  = num2[DATA_WIDTH-2:0];

    // Different signs: the positive operand wins; same sign: compare magnitudes,
    // with the sense flipped for negatives.
    always_comb begin
        result = 1'b0;
        if (sign1 != sign2) begin
            result = ~sign1;
        end else if (!sign1) begin
            result = (mag1 > mag2);
        end else begin
            result = (mag1 < mag2);
        end
    end

endmodule

// File: rtl/fp_argext_scheduler.sv
// Sequential arg-max / arg-min over a run of FP16 candidates using one shared comparator.
module fp_argext_scheduler
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_argext_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [IDX_W:0] LEN_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W:0]        len_q;
    logic                  find_min_q;
    logic [IDX_W:0]        count_q;
    logic [DATA_WIDTH-1:0] best_val_q;
    logic [IDX_W-1:0]      best_idx_q;
    logic                  res_valid_q;

    logic                  accept;
    logic                  last_accept;
    logic                  take;
    logic                  cmp_gt;
    logic [DATA_WIDTH-1:0] cmp_a;
    logic [DATA_WIDTH-1:0] cmp_b;

    assign accept      = bus.in_valid && (state_q == SCAN);
    assign last_accept = accept && (count_q == (len_q - LEN_ONE));

    // Operand order swaps with mode so a single greater-than serves both max and min.
    assign cmp_a = find_min_q ? best_val_q : bus.in_data;
    assign cmp_b = find_min_q ? bus.in_data : best_val_q;
    assign take  = (count_q == '0) || cmp_gt;

    fp_comparator #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .num1   (cmp_a),
        .num2   (cmp_b),
        .result (cmp_gt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: start only in IDLE, leave SCAN on the last accept, leave DONE on handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (last_accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Run parameters, element counter and running best value/index.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            find_min_q <= 1'b0;
            count_q    <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            len_q      <= bus.len;
            find_min_q <= bus.find_min;
            count_q    <= '0;
            best_val_q <= FP16_ZERO;
            best_idx_q <= '0;
        end else if (accept) begin
            count_q <= count_q + LEN_ONE;
            if (take) begin
                best_val_q <= bus.in_data;
                best_idx_q <= count_q[IDX_W-1:0];
            end
        end
    end

    // Result flag rises on the cycle after DONE is entered and drops with the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
        end else if (state_q == DONE) begin
            res_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready  = (state_q == SCAN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_val   = best_val_q;
    assign bus.res_idx   = best_idx_q;

endmodule

// File: tb/tb_fp_argext_scheduler.sv
// Self-checking bench for fp_argext_scheduler: directed runs plus randomized runs against
// an ordering model that maps FP16 to a signed integer key.
module tb_fp_argext_scheduler;

    localparam int DW      = 16;
    localparam int MAX_LEN = 1024;
    localparam int IDX_W   = $clog2(MAX_LEN);

    logic clk;
    logic rst;

    fp_argext_scheduler_if #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN)) bus ();

    fp_argext_scheduler #(
        .DATA_WIDTH (DW),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total;
    int          n_pass;
    logic        exp_valid;
    logic [15:0] exp_val;
    int          exp_idx;
    logic [15:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Sign-magnitude FP16 mapped to an integer with the same ordering.
    function automatic int okey(input logic [15:0] v);
        int m;
        m = int'({17'b0, v[14:0]});
        return v[15] ? -m : m;
    endfunction

    task automatic model(input bit fm, input int n, input logic [15:0] d[$],
                         output logic [15:0] val, output int idx);
        val = 16'h0000;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || (fm ? (okey(d[i]) < okey(val)) : (okey(d[i]) > okey(val)))) begin
                val = d[i];
                idx = i;
            end
        end
    endtask

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[14:10] == 5'h1f) v[14:10] = 5'h1e;
        if (v == 16'h8000) v = 16'h0000;
        return v;
    endfunction

    // gap: 0 none, 1 invalid cycle between every element, 2 random gaps.
    task automatic run(input bit fm, input int n, input logic [15:0] d[$], input int gap,
                       input int hold, input bit mid_start, input bit use_lit,
                       input logic [15:0] lv, input int li, input string tag);
        logic [15:0] mv;
        int          mi;
        int          wt;
        model(fm, n, d, mv, mi);
        if (use_lit) begin
            chk({tag, "_model_val"}, 32'(mv), 32'(lv));
            chk({tag, "_model_idx"}, 32'(mi), 32'(li));
        end
        exp_val   = mv;
        exp_idx   = mi;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.len      = 11'(n);
        bus.find_min = fm;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.len      = 11'($urandom_range(0, 20));
        bus.find_min = ~fm;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))) begin
                bus.in_valid = 1'b0;
                bus.in_data  = rand_fp();
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            if (mid_start && i == 1) begin
                bus.start = 1'b1;
                bus.len   = 11'd1;
            end
            wt = 0;
            @(negedge clk);
            while (!bus.in_ready && wt < 16) begin
                @(negedge clk);
                wt++;
            end
            if (!bus.in_ready) chk({tag, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = rand_fp();
        @(negedge clk);
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_res_valid_early"}, 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        if (use_lit) begin
            chk({tag, "_res_val"}, 32'(bus.res_val), 32'(lv));
            chk({tag, "_res_idx"}, 32'(bus.res_idx), 32'(li));
        end
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_res_valid_hold"}, 32'(bus.res_valid), 32'd1);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        exp_valid     = 1'b0;
        @(negedge clk);
        chk({tag, "_res_valid_cleared"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          fm;
        n_total       = 0;
        n_pass        = 0;
        exp_valid     = 1'b0;
        exp_val       = '0;
        exp_idx       = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.find_min  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;

        // Continuous result check whenever a result is presented.
        fork
            forever begin
                @(negedge clk);
                if (bus.res_valid === 1'b1) begin
                    chk("res_expected", 32'(exp_valid), 32'd1);
                    if (exp_valid) begin
                        chk("res_val_model", 32'(bus.res_val), 32'(exp_val));
                        chk("res_idx_model", 32'(bus.res_idx), 32'(exp_idx));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset_res_val", 32'(bus.res_val), 32'd0);
        chk("reset_res_idx", 32'(bus.res_idx), 32'd0);

        q = '{16'h3C00, 16'h4000, 16'hBC00, 16'h70ED, 16'h515D};
        run(1'b0, 5, q, 0, 0, 1'b0, 1'b1, 16'h70ED, 3, "t1_max");
        run(1'b1, 5, q, 0, 0, 1'b0, 1'b1, 16'hBC00, 2, "t2_min");

        q = '{16'hBC00, 16'hC000, 16'hBC43, 16'hBC00};
        run(1'b0, 4, q, 0, 0, 1'b0, 1'b1, 16'hBC00, 0, "t3_neg_max");
        run(1'b1, 4, q, 0, 0, 1'b0, 1'b1, 16'hC000, 1, "t3_neg_min");
        q = '{16'h4000, 16'h4000};
        run(1'b0, 2, q, 0, 0, 1'b0, 1'b1, 16'h4000, 0, "t3_tie");

        q = '{16'hAC4A};
        run(1'b0, 1, q, 0, 0, 1'b0, 1'b1, 16'hAC4A, 0, "t4_len1");
        q = {};
        run(1'b0, 0, q, 0, 0, 1'b0, 1'b1, 16'h0000, 0, "t4_len0");
        q = '{16'h3C00, 16'h4000, 16'hBC00, 16'h70ED, 16'h515D};
        run(1'b1, 5, q, 0, 5, 1'b0, 1'b1, 16'hBC00, 2, "t4_hold");

        q = '{16'h47A6, 16'h6C22, 16'h3C00, 16'h0000};
        run(1'b0, 4, q, 1, 0, 1'b0, 1'b1, 16'h6C22, 1, "t5_gaps");

        q = '{16'h3C00, 16'h4000, 16'hBC00, 16'h70ED, 16'h515D};
        run(1'b0, 5, q, 0, 0, 1'b1, 1'b1, 16'h70ED, 3, "t6_mid_start");

        // Reset in the middle of a scan.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 11'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h5000 + 16'(i);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("t6_rst_res_val", 32'(bus.res_val), 32'd0);
        chk("t6_rst_res_idx", 32'(bus.res_idx), 32'd0);
        q = '{16'h3C00, 16'h4000, 16'hBC00, 16'h70ED, 16'h515D};
        run(1'b0, 5, q, 0, 0, 1'b0, 1'b1, 16'h70ED, 3, "t6_after_rst");

        for (int r = 0; r < 24; r++) begin
            n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
            fm = 1'($urandom_range(0, 1));
            q  = {};
            for (int i = 0; i < n; i++) q.push_back(rand_fp());
            run(fm, n, q, 2, int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0000, 0, "rand");
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
